// File: rtl/data_sync.sv
// -----------------------------------------------------------------------------
// data_sync
//
// Destination-domain bus synchronizer. A multi-bit bus from a foreign clock
// domain is qualified by a level enable; only the enable crosses through a
// flop chain. The bus is captured once, in the cycle the synchronized enable
// rises, and a one-cycle strobe marks the update. A wrapping counter records
// completed captures.
//
// Parameters
//   NUM_STAGES  enable synchronizer depth (2..4, anything else fails elaboration)
//   BUS_WIDTH   width of unsync_bus / sync_bus
//   CNT_WIDTH   width of xfer_count
//
// Ports
//   clk          destination-domain clock
//   rst          asynchronous reset, active-high (driven by the reset synchronizer)
//   unsync_bus   source-domain data, held stable while bus_enable is high
//   bus_enable   source-domain level qualifier, asynchronous to clk
//   sync_bus     captured data, registered; holds its value between captures
//   enable_pulse one-cycle strobe, high in the cycle sync_bus has just updated
//   busy         high from capture until the synchronized enable returns low
//   xfer_count   number of completed captures, wraps modulo 2**CNT_WIDTH
//   sync_ack     (only with DATA_SYNC_ACK_EN) 4-phase handshake level back to
//                the source: set leaving CAPTURE, cleared on HOLD -> IDLE
//
// Configuration macro: DATA_SYNC_ACK_EN
// -----------------------------------------------------------------------------
module data_sync #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] xfer_count
`ifdef DATA_SYNC_ACK_EN
    ,
    output logic                 sync_ack
`endif
);

    // Depth outside 2..4 either gives no metastability protection or adds
    // latency nobody asked for; refuse to build.
    generate
        if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
            $error("data_sync: NUM_STAGES must be in the range 2..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [NUM_STAGES-1:0] en_sync;
    logic                  enable_s;
    logic                  pulse_ff;
    logic                  rise;
    logic                  capture;

    // -------------------------------------------------------------------------
    // Enable synchronizer. Only this single bit crosses domains; the bus is
    // safe to sample because the source holds it stable while enable is high.
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all flops see
    // the pre-edge values of each other; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sync  <= '0;
            pulse_ff <= 1'b0;
        end else begin
            en_sync  <= {en_sync[NUM_STAGES-2:0], bus_enable};
            pulse_ff <= enable_s;
        end
    end

    assign enable_s = en_sync[NUM_STAGES-1];
    assign rise     = enable_s & ~pulse_ff;

    // -------------------------------------------------------------------------
    // Control FSM: IDLE waits for a synchronized rising edge, CAPTURE lasts one
    // cycle, HOLD waits for the synchronized enable to drop so a long enable
    // never yields a second capture.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults are assigned before the case so every path drives every
    // output of this block and no latch is inferred.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_next = ST_CAPTURE;
                    capture    = 1'b1;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!enable_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath. The bus is sampled on the IDLE -> CAPTURE edge, so sync_bus,
    // the counter and enable_pulse all change on the same edge and are seen
    // together by the consumer while the FSM sits in CAPTURE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_bus   <= '0;
            xfer_count <= '0;
        end else if (capture) begin
            sync_bus   <= unsync_bus;
            xfer_count <= xfer_count + CNT_WIDTH'(1);
        end
    end

    // Status outputs come straight from flops decoded off the next state, so
    // they are glitch-free and aligned with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            enable_pulse <= (state_next == ST_CAPTURE);
            busy         <= (state_next != ST_IDLE);
        end
    end

`ifdef DATA_SYNC_ACK_EN
    // High exactly while the FSM is in HOLD: set leaving CAPTURE, cleared on
    // the HOLD -> IDLE edge, so the source sees the level only after the data
    // has been captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ack <= 1'b0;
        end else begin
            sync_ack <= (state_next == ST_HOLD);
        end
    end
`endif

endmodule
